ram_copy_engine: RTL and testbench

Initiator-side companion to the single-port word RAM: a sequential engine that drives the RAM's address, write-data and write-enable inputs and consumes its combinational read data. It performs block copy (read source word, write destination word) or block fill (write a constant) over a contiguous address range, one command at a time. It sits between a control master (CPU/CSR logic) and the RAM and owns the RAM port while busy.

---
 rtl/ram_copy_engine.sv | 191 +++++++++++++++++++
 tb/tb_ram_copy_engine.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_copy_engine.sv
// Block copy / block fill engine driving a single-port word RAM with combinational read data.
// One command at a time; every output is registered and derived from the next-state values.
module ram_copy_engine #(
    parameter int XLen = 32,
    parameter int NPos = 1024,
    localparam int NPosWidth = $clog2(NPos)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 mode_i,
    input  logic [NPosWidth-1:0] src_i,
    input  logic [NPosWidth-1:0] dst_i,
    input  logic [NPosWidth:0]   len_i,
    input  logic [XLen-1:0]      fill_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [NPosWidth-1:0] ram_a_o,
    output logic [XLen-1:0]      ram_wd_o,
    output logic                 ram_we_o,
    input  logic [XLen-1:0]      ram_rd_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [NPosWidth+1:0] NPosExt = (NPosWidth+2)'(NPos);

    state_t               state_r, state_s;
    logic                 mode_r, mode_s;
    logic [NPosWidth-1:0] src_r, src_s;
    logic [NPosWidth-1:0] dst_r, dst_s;
    logic [NPosWidth:0]   len_r, len_s;
    logic [NPosWidth:0]   i_r, i_s, i_inc_s;
    logic [XLen-1:0]      fill_r, fill_s;
    logic [XLen-1:0]      buf_r, buf_s;
    logic                 err_r, err_s;

    logic                 busy_r, busy_s;
    logic                 done_r, done_s;
    logic                 we_r, we_s;
    logic [NPosWidth-1:0] a_r, a_s;
    logic [XLen-1:0]      wd_r, wd_s;

    // Sums are widened by two bits so an out-of-range end can never wrap back into range.
    function automatic logic range_error(input logic                 mode,
                                         input logic [NPosWidth-1:0] src,
                                         input logic [NPosWidth-1:0] dst,
                                         input logic [NPosWidth:0]   len);
        logic [NPosWidth+1:0] dst_end;
        logic [NPosWidth+1:0] src_end;
        dst_end = {2'b00, dst} + {1'b0, len};
        src_end = {2'b00, src} + {1'b0, len};
        return (dst_end > NPosExt) || (!mode && (src_end > NPosExt));
    endfunction

    assign i_inc_s = i_r + {{NPosWidth{1'b0}}, 1'b1};

    // Next-state and command/data register update logic.
    always_comb begin
        state_s = state_r;
        mode_s  = mode_r;
        src_s   = src_r;
        dst_s   = dst_r;
        len_s   = len_r;
        i_s     = i_r;
        fill_s  = fill_r;
        buf_s   = buf_r;
        err_s   = err_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    mode_s = mode_i;
                    src_s  = src_i;
                    dst_s  = dst_i;
                    len_s  = len_i;
                    fill_s = fill_i;
                    i_s    = '0;
                    if (range_error(mode_i, src_i, dst_i, len_i)) begin
                        err_s   = 1'b1;
                        state_s = ST_DONE;
                    end else if (len_i == '0) begin
                        err_s   = 1'b0;
                        state_s = ST_DONE;
                    end else begin
                        err_s   = 1'b0;
                        state_s = mode_i ? ST_WR : ST_RD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD: begin
                buf_s   = ram_rd_i;
                state_s = ST_WR;
            end
            ST_WR: begin
                i_s = i_inc_s;
                if (i_inc_s == len_r) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = mode_r ? ST_WR : ST_RD;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the upcoming cycle, decoded from the next state so they can be registered.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        we_s   = 1'b0;
        a_s    = '0;
        wd_s   = '0;
        case (state_s)
            ST_RD: begin
                busy_s = 1'b1;
                a_s    = src_s + i_s[NPosWidth-1:0];
            end
            ST_WR: begin
                busy_s = 1'b1;
                we_s   = 1'b1;
                a_s    = dst_s + i_s[NPosWidth-1:0];
                wd_s   = mode_s ? fill_s : buf_s;
            end
            ST_DONE: begin
                done_s = 1'b1;
            end
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // State, command and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            mode_r  <= 1'b0;
            src_r   <= '0;
            dst_r   <= '0;
            len_r   <= '0;
            i_r     <= '0;
            fill_r  <= '0;
            buf_r   <= '0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            we_r    <= 1'b0;
            a_r     <= '0;
            wd_r    <= '0;
        end else begin
            state_r <= state_s;
            mode_r  <= mode_s;
            src_r   <= src_s;
            dst_r   <= dst_s;
            len_r   <= len_s;
            i_r     <= i_s;
            fill_r  <= fill_s;
            buf_r   <= buf_s;
            err_r   <= err_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            we_r    <= we_s;
            a_r     <= a_s;
            wd_r    <= wd_s;
        end
    end

    assign busy_o   = busy_r;
    assign done_o   = done_r;
    assign err_o    = err_r;
    assign ram_we_o = we_r;
    assign ram_a_o  = a_r;
    assign ram_wd_o = wd_r;

endmodule

// File: tb/tb_ram_copy_engine.sv
// Directed self-checking bench for ram_copy_engine with a behavioural single-port RAM.
// Expected values are hand-computed from the command parameters and preload contents.
module tb_ram_copy_engine;

    localparam int XLen = 32;
    localparam int NPos = 1024;
    localparam int AW   = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            mode = 1'b0;
    logic [AW-1:0]   src = '0;
    logic [AW-1:0]   dst = '0;
    logic [AW:0]     len = '0;
    logic [XLen-1:0] fill = '0;
    logic            busy_o, done_o, err_o, ram_we_o;
    logic [AW-1:0]   ram_a_o;
    logic [XLen-1:0] ram_wd_o, ram_rd;

    logic [XLen-1:0] mem [NPos];
    logic            pre_we = 1'b0;
    logic [AW-1:0]   pre_a = '0;
    logic [XLen-1:0] pre_d = '0;

    int n_checks = 0;
    int n_pass   = 0;
    int busy_n, done_c, we_n, bad;

    ram_copy_engine #(.XLen(XLen), .NPos(NPos)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .mode_i   (mode),
        .src_i    (src),
        .dst_i    (dst),
        .len_i    (len),
        .fill_i   (fill),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .err_o    (err_o),
        .ram_a_o  (ram_a_o),
        .ram_wd_o (ram_wd_o),
        .ram_we_o (ram_we_o),
        .ram_rd_i (ram_rd)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: synchronous write, combinational read; bench preload port shares the write path.
    always @(posedge clk) begin
        if (ram_we_o) mem[ram_a_o] <= ram_wd_o;
        else if (pre_we) mem[pre_a] <= pre_d;
    end
    assign ram_rd = mem[ram_a_o];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic preload(input int a, input logic [31:0] d);
        pre_we = 1'b1;
        pre_a  = AW'(a);
        pre_d  = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // Issues one command and observes cycles 1.. after the accepting edge until done_o.
    // inj > 0 pulses a bogus fill command in that cycle, which must be ignored.
    task automatic run_cmd(input logic m, input int s, input int d, input int l,
                           input logic [31:0] f, input int inj,
                           output int busy_cnt, output int done_cyc, output int we_cnt);
        start = 1'b1; mode = m; src = AW'(s); dst = AW'(d); len = (AW+1)'(l); fill = f;
        @(posedge clk); #1;
        start = 1'b0;
        busy_cnt = 0; we_cnt = 0; done_cyc = -1;
        for (int c = 1; c <= 3000; c++) begin
            if (c == inj) begin
                start = 1'b1; mode = 1'b1; dst = 10'd500; len = 11'd1; fill = 32'hFFFF_FFFF;
            end else begin
                start = 1'b0;
            end
            busy_cnt += int'(busy_o);
            we_cnt   += int'(ram_we_o);
            if (done_o) begin
                done_cyc = c;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    initial begin
        #1;
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        check("reset_done", {31'd0, done_o}, 32'd0);
        check("reset_err", {31'd0, err_o}, 32'd0);
        check("reset_we", {31'd0, ram_we_o}, 32'd0);
        check("reset_addr", {22'd0, ram_a_o}, 32'd0);
        check("reset_wd", ram_wd_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        preload(0, 32'hAAAA_0000);
        preload(1, 32'hBBBB_0001);
        preload(2, 32'hCCCC_0002);
        preload(3, 32'hDDDD_0003);
        preload(104, 32'h55AA_55AA);
        preload(10, 32'hCAFE_0010);
        for (int k = 11; k <= 13; k++) preload(k, 32'd0);
        preload(500, 32'h0BAD_0500);
        for (int k = 200; k <= 203; k++) preload(k, 32'h0000_1111);

        // Basic copy of four words.
        run_cmd(1'b0, 0, 100, 4, 32'd0, 0, busy_n, done_c, we_n);
        check("copy_busy_cycles", busy_n, 8);
        check("copy_done_cycle", done_c, 9);
        check("copy_writes", we_n, 4);
        check("copy_err", {31'd0, err_o}, 32'd0);
        @(posedge clk); #1;
        check("copy_done_single", {31'd0, done_o}, 32'd0);
        check("copy_m100", mem[100], 32'hAAAA_0000);
        check("copy_m101", mem[101], 32'hBBBB_0001);
        check("copy_m102", mem[102], 32'hCCCC_0002);
        check("copy_m103", mem[103], 32'hDDDD_0003);
        check("copy_m104_untouched", mem[104], 32'h55AA_55AA);

        // Overlapping copy replicates the first source word.
        run_cmd(1'b0, 10, 11, 3, 32'd0, 0, busy_n, done_c, we_n);
        check("ovl_done_cycle", done_c, 7);
        check("ovl_m11", mem[11], 32'hCAFE_0010);
        check("ovl_m12", mem[12], 32'hCAFE_0010);
        check("ovl_m13", mem[13], 32'hCAFE_0010);
        @(posedge clk); #1;

        // start_i during a busy copy must be ignored.
        run_cmd(1'b0, 0, 700, 2, 32'd0, 2, busy_n, done_c, we_n);
        check("ign_done_cycle", done_c, 5);
        check("ign_writes", we_n, 2);
        check("ign_m700", mem[700], 32'hAAAA_0000);
        check("ign_m701", mem[701], 32'hBBBB_0001);
        check("ign_m500_untouched", mem[500], 32'h0BAD_0500);
        @(posedge clk); #1;

        // Fill at the top of the RAM.
        run_cmd(1'b1, 0, 1020, 4, 32'hDEAD_BEEF, 0, busy_n, done_c, we_n);
        check("fill_busy_cycles", busy_n, 4);
        check("fill_done_cycle", done_c, 5);
        check("fill_writes", we_n, 4);
        for (int k = 1020; k <= 1023; k++) check("fill_top_word", mem[k], 32'hDEAD_BEEF);
        @(posedge clk); #1;

        // Source range error.
        run_cmd(1'b0, 1022, 0, 3, 32'd0, 0, busy_n, done_c, we_n);
        check("err_done_cycle", done_c, 1);
        check("err_busy_cycles", busy_n, 0);
        check("err_writes", we_n, 0);
        check("err_flag", {31'd0, err_o}, 32'd1);
        @(posedge clk); #1;
        check("err_flag_holds", {31'd0, err_o}, 32'd1);

        // Zero length clears the error flag and touches nothing.
        run_cmd(1'b0, 0, 0, 0, 32'd0, 0, busy_n, done_c, we_n);
        check("len0_done_cycle", done_c, 1);
        check("len0_busy_cycles", busy_n, 0);
        check("len0_writes", we_n, 0);
        check("len0_err", {31'd0, err_o}, 32'd0);
        @(posedge clk); #1;

        // Reset in cycle 3 of a four-word copy: only word 0 lands.
        start = 1'b1; mode = 1'b0; src = 10'd0; dst = 10'd200; len = 11'd4;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_we_cycle2", {31'd0, ram_we_o}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_mid_we", {31'd0, ram_we_o}, 32'd0);
        check("rst_mid_busy", {31'd0, busy_o}, 32'd0);
        check("rst_mid_done", {31'd0, done_o}, 32'd0);
        check("rst_mid_err", {31'd0, err_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_m200", mem[200], 32'hAAAA_0000);
        check("rst_mid_m201", mem[201], 32'h0000_1111);
        check("rst_mid_m203", mem[203], 32'h0000_1111);
        run_cmd(1'b1, 0, 300, 2, 32'h0000_0077, 0, busy_n, done_c, we_n);
        check("post_rst_done_cycle", done_c, 3);
        check("post_rst_m300", mem[300], 32'h0000_0077);
        check("post_rst_m301", mem[301], 32'h0000_0077);
        @(posedge clk); #1;

        // Full-range fill is legal.
        run_cmd(1'b1, 0, 0, 1024, 32'h1357_9BDF, 0, busy_n, done_c, we_n);
        check("full_done_cycle", done_c, 1025);
        check("full_writes", we_n, 1024);
        check("full_err", {31'd0, err_o}, 32'd0);
        bad = 0;
        for (int k = 0; k < NPos; k++) if (mem[k] !== 32'h1357_9BDF) bad++;
        check("full_bad_words", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
